// File: rtl/data_mem_bridge_if.sv
// Data-side bus between the load/store bridge and memory: registered
// request with byte enables, single-cycle ack carrying read data.
interface data_mem_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-3:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/data_mem_bridge.sv
// Load/store stage behind a single-cycle CPU data port. Turns the CPU's
// combinational access into a req/ack bus transaction, stalls the CPU until
// it completes, and formats load data (lane select, sign/zero extend).
module data_mem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_width,
    input  logic        cpu_unsigned,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_fault,
    data_mem_bridge_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic              req_q, we_q, uns_q, tflag_q;
    logic [ADDR_W-3:0] addr_q;
    logic [1:0]        lo_q, width_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [CW-1:0]     cnt_q;

    logic aligned, valid, start, ack_done, to_done;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    // Load data formatting: pick the addressed lane, then extend.
    function automatic logic [31:0] fmt_load(logic [31:0] rd, logic [1:0] lo,
                                             logic [1:0] w, logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lo, 3'b000} +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (w)
            2'b00:   return u ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return u ? {16'b0, h} : {{16{h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    // Access legality and store lane placement from the raw CPU request.
    always_comb begin
        aligned  = 1'b1;
        st_be    = 4'b1111;
        st_wdata = cpu_wdata;
        case (cpu_width)
            2'b00: begin
                st_be    = 4'b0001 << cpu_addr[1:0];
                st_wdata = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                aligned  = ~cpu_addr[0];
                st_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{cpu_wdata[15:0]}};
            end
            2'b10:   aligned = (cpu_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        valid = (cpu_read ^ cpu_write) & aligned & (cpu_width != 2'b11);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, CPU handshake outputs and datapath strobes.
    always_comb begin
        state_d   = state_q;
        cpu_stall = 1'b0;
        cpu_fault = 1'b0;
        start     = 1'b0;
        ack_done  = 1'b0;
        to_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    cpu_stall = 1'b1;
                    start     = 1'b1;
                    state_d   = REQ;
                end else if (cpu_read | cpu_write) begin
                    cpu_fault = 1'b1;
                end
            end
            REQ: begin
                cpu_stall = 1'b1;
                if (bus.bus_ack) begin
                    ack_done = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    to_done = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // CPU commits this cycle; a request still asserted is the
                // one just served, so it is not restarted.
                cpu_fault = tflag_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched transaction, request flop, timeout counter and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            lo_q    <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            width_q <= '0;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            tflag_q <= 1'b0;
            rdata_q <= '0;
        end else if (start) begin
            req_q   <= 1'b1;
            we_q    <= cpu_write;
            addr_q  <= cpu_addr[ADDR_W-1:2];
            lo_q    <= cpu_addr[1:0];
            be_q    <= cpu_write ? st_be : 4'b0000;
            wdata_q <= st_wdata;
            width_q <= cpu_width;
            uns_q   <= cpu_unsigned;
            cnt_q   <= '0;
            tflag_q <= 1'b0;
        end else if (ack_done) begin
            req_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0 : fmt_load(bus.bus_rdata, lo_q, width_q, uns_q);
        end else if (to_done) begin
            req_q   <= 1'b0;
            tflag_q <= 1'b1;
            rdata_q <= '0;
        end else if (state_q == REQ) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cpu_rdata     = (state_q == DONE) ? rdata_q : 32'h0;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge with TIMEOUT=4.
module tb_data_mem_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0, cpu_unsigned = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [1:0]  cpu_width = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, cpu_fault;
    int          n_tests = 0, n_fail = 0;

    data_mem_bridge_if #(.ADDR_W(32)) bus_if ();

    data_mem_bridge #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_width(cpu_width), .cpu_unsigned(cpu_unsigned),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_fault(cpu_fault),
        .bus(bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] wid, input logic u);
        cpu_read = r; cpu_write = w; cpu_addr = a;
        cpu_wdata = wd; cpu_width = wid; cpu_unsigned = u;
    endtask

    // Full load with ack on the first REQ cycle; ends at the DONE negedge.
    task automatic run_load(input string tag, input logic [31:0] a, input logic [1:0] wid,
                            input logic u, input logic [31:0] rd, input logic [31:0] exp);
        tick();
        cpu_set(1'b1, 1'b0, a, 32'h0, wid, u);
        @(negedge clk);
        chk({tag, "_stall0"}, 32'(cpu_stall), 32'd1);
        tick();
        @(negedge clk);
        chk({tag, "_req"}, 32'(bus_if.bus_req), 32'd1);
        chk({tag, "_be"}, 32'(bus_if.bus_be), 32'h0);
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = rd;
        tick();
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_done_stall"}, 32'(cpu_stall), 32'd0);
        chk({tag, "_rdata"}, cpu_rdata, exp);
    endtask

    initial begin
        int nreq, stalls;
        bit done;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = '0;

        // Reset state
        #12;
        chk("rst_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_be", 32'(bus_if.bus_be), 32'd0);
        chk("rst_addr", 32'(bus_if.bus_addr), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        rst_n = 1'b1;

        // lb at 0x1003, signed
        tick();
        cpu_set(1'b1, 1'b0, 32'h1003, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        chk("lb_stall_idle", 32'(cpu_stall), 32'd1);
        chk("lb_req_idle", 32'(bus_if.bus_req), 32'd0);
        tick();
        @(negedge clk);
        chk("lb_req", 32'(bus_if.bus_req), 32'd1);
        chk("lb_be", 32'(bus_if.bus_be), 32'h0);
        chk("lb_we", 32'(bus_if.bus_we), 32'd0);
        chk("lb_addr", 32'(bus_if.bus_addr), 32'h400);
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 32'h80FF_0000;
        tick();
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk("lb_done_stall", 32'(cpu_stall), 32'd0);
        chk("lb_rdata", cpu_rdata, 32'hFFFF_FF80);
        chk("lb_fault", 32'(cpu_fault), 32'd0);
        chk("lb_done_req", 32'(bus_if.bus_req), 32'd0);
        // request still held in DONE must not restart
        tick();
        @(negedge clk);
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        chk("lb_norestart", 32'(bus_if.bus_req), 32'd0);

        // sh at 0x2002
        tick();
        cpu_set(1'b0, 1'b1, 32'h2002, 32'h1234_ABCD, 2'b01, 1'b0);
        stalls = 0;
        @(negedge clk);
        stalls += int'(cpu_stall);
        tick();
        @(negedge clk);
        stalls += int'(cpu_stall);
        chk("sh_req", 32'(bus_if.bus_req), 32'd1);
        chk("sh_be", 32'(bus_if.bus_be), 32'hC);
        chk("sh_wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(bus_if.bus_we), 32'd1);
        chk("sh_addr", 32'(bus_if.bus_addr), 32'h800);
        bus_if.bus_ack = 1'b1;
        tick();
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        stalls += int'(cpu_stall);
        chk("sh_stall_cycles", 32'(stalls), 32'd2);
        chk("sh_rdata", cpu_rdata, 32'd0);
        tick();
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

        // misaligned / illegal accesses
        tick();
        cpu_set(1'b1, 1'b0, 32'h0006, 32'h0, 2'b10, 1'b0);
        @(negedge clk);
        chk("mis_fault", 32'(cpu_fault), 32'd1);
        chk("mis_stall", 32'(cpu_stall), 32'd0);
        chk("mis_rdata", cpu_rdata, 32'd0);
        tick();
        @(negedge clk);
        chk("mis_noreq", 32'(bus_if.bus_req), 32'd0);
        cpu_set(1'b1, 1'b0, 32'h0001, 32'h0, 2'b01, 1'b0);
        #1 chk("mis_half_fault", 32'(cpu_fault), 32'd1);
        cpu_set(1'b1, 1'b0, 32'h0000, 32'h0, 2'b11, 1'b0);
        #1 chk("ill_width_fault", 32'(cpu_fault), 32'd1);
        cpu_set(1'b1, 1'b1, 32'h0000, 32'h0, 2'b10, 1'b0);
        #1 chk("ill_rw_fault", 32'(cpu_fault), 32'd1);
        tick();
        @(negedge clk);
        chk("ill_noreq", 32'(bus_if.bus_req), 32'd0);
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

        // timeout: no ack, TIMEOUT=4
        tick();
        cpu_set(1'b1, 1'b0, 32'h0010, 32'h0, 2'b10, 1'b0);
        bus_if.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        nreq = 0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            @(negedge clk);
            if (bus_if.bus_req) nreq++;
            if (!cpu_stall) begin
                done = 1'b1;
                chk("to_fault", 32'(cpu_fault), 32'd1);
                chk("to_rdata", cpu_rdata, 32'd0);
            end
        end
        chk("to_finished", 32'(done), 32'd1);
        chk("to_req_cycles", 32'(nreq), 32'd4);
        tick();
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        chk("to_fault_clear", 32'(cpu_fault), 32'd0);

        // reset during REQ
        tick();
        cpu_set(1'b1, 1'b0, 32'h0040, 32'h0, 2'b10, 1'b0);
        tick();
        @(negedge clk);
        chk("rr_req", 32'(bus_if.bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_req_drop", 32'(bus_if.bus_req), 32'd0);
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_idle_stall", 32'(cpu_stall), 32'd0);
        // stall on first cycle of a new access proves IDLE, not DONE
        run_load("rr_lw", 32'h0020, 2'b10, 1'b0, 32'h1357_9BDF, 32'h1357_9BDF);

        // back-to-back sw then lbu
        tick();
        cpu_set(1'b0, 1'b1, 32'h0000, 32'h00FF_00A5, 2'b10, 1'b0);
        @(negedge clk);
        chk("sw_stall", 32'(cpu_stall), 32'd1);
        tick();
        @(negedge clk);
        chk("sw_be", 32'(bus_if.bus_be), 32'hF);
        chk("sw_wdata", bus_if.bus_wdata, 32'h00FF_00A5);
        bus_if.bus_ack = 1'b1;
        tick();
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk("sw_done_stall", 32'(cpu_stall), 32'd0);
        run_load("lbu", 32'h0000, 2'b00, 1'b1, 32'h00FF_00A5, 32'h0000_00A5);
        run_load("lh_hi", 32'h0002, 2'b01, 1'b0, 32'h8001_7FFF, 32'hFFFF_8001);
        run_load("lhu_hi", 32'h0002, 2'b01, 1'b1, 32'h8001_7FFF, 32'h0000_8001);
        run_load("lb_pos", 32'h0001, 2'b00, 1'b0, 32'h1234_7F00, 32'h0000_007F);
        run_load("lw_uns", 32'h0004, 2'b10, 1'b1, 32'h8765_4321, 32'h8765_4321);
        tick();
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
